ifetch: RTL

- Instruction fetch sequencer: the consumer and driver of the instruction counter.
- Takes the current IC value as a memory address and runs a four-phase read handshake with the memory bus.
- Latches the returned word into the instruction register.
- Issues the one-cycle active-low count-up strobe (cu_) that advances IC.
- Sits between the control unit (fetch request) and the IC/memory interface.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_tmo.sv | 31 +++
 rtl/ifetch.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

  localparam int WORD_W      = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_tmo.sv
// ifetch_tmo: REQ watchdog counter. Clear has priority over enable; exp_o
// flags the last allowed cycle (count == LIMIT-1).
module ifetch_tmo #(
  parameter int LIMIT = 16,
  parameter int TW    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TW'(1);
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign exp_o = (cnt_q == TW'(LIMIT - 1));

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch sequencer. Latches ic as the bus address, runs a
// four-phase read handshake, captures the word into ir and strobes cu_ low
// for one cycle to advance the instruction counter.
// Build option: define IFETCH_TIMEOUT_EN to add a REQ watchdog that raises
// alarm and returns to IDLE when memory never answers.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 8
) (
  input  logic              clk_sys,
  input  logic              clr_,
  input  logic              fetch,
  input  logic              abort,
  input  logic [0:WORD_W-1] ic,
  output logic [0:WORD_W-1] ad,
  output logic              mem_rq,
  input  logic              mem_ok,
  input  logic [0:WORD_W-1] dt,
  output logic [0:WORD_W-1] ir,
  output logic              ir_valid,
  output logic              cu_,
  output logic              busy,
  output logic              alarm
);

  // reject configurations the watchdog counter cannot represent
  if (TIMEOUT < 2 || TIMEOUT > 255 || TIMEOUT >= (1 << TW)) begin : g_cfg_err
    $error("ifetch: TIMEOUT must be 2..255 and below 2**TW");
  end

  fetch_state_e      state_q;
  logic [0:WORD_W-1] ad_q, ir_q;
  logic              mem_rq_q, ir_valid_q, cu_q;
  logic              aborted_q;
  // set once mem_ok has been seen low for this fetch; an acknowledge left
  // over from an earlier transaction must drop before it can count
  logic              armed_q;

`ifdef IFETCH_TIMEOUT_EN
  logic alarm_q;
  logic tmo_exp;

  ifetch_tmo #(
    .LIMIT (TIMEOUT),
    .TW    (TW)
  ) u_tmo (
    .clk_i  (clk_sys),
    .rst_ni (clr_),
    .clr_i  (state_q == IDLE),
    .en_i   (state_q == REQ),
    .exp_o  (tmo_exp)
  );
`endif

  // fetch sequencer with registered bus/strobe outputs
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      state_q    <= IDLE;
      ad_q       <= '0;
      ir_q       <= '0;
      mem_rq_q   <= 1'b0;
      ir_valid_q <= 1'b0;
      cu_q       <= 1'b1;
      aborted_q  <= 1'b0;
      armed_q    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      alarm_q    <= 1'b0;
`endif
    end else begin
      // pulses last exactly one cycle
      ir_valid_q <= 1'b0;
      cu_q       <= 1'b1;
`ifdef IFETCH_TIMEOUT_EN
      alarm_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fetch && !abort) begin
            ad_q      <= ic;
            mem_rq_q  <= 1'b1;
            aborted_q <= 1'b0;
            armed_q   <= !mem_ok;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (!mem_ok) armed_q <= 1'b1;
          if (abort) begin
            mem_rq_q  <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= REL;
          end else if (mem_ok && armed_q) begin
            ir_q     <= dt;
            mem_rq_q <= 1'b0;
            state_q  <= REL;
`ifdef IFETCH_TIMEOUT_EN
          end else if (tmo_exp) begin
            mem_rq_q <= 1'b0;
            alarm_q  <= 1'b1;
            state_q  <= IDLE;
`endif
          end
        end
        REL: begin
          if (!mem_ok) begin
            state_q <= DONE;
            if (!aborted_q) begin
              cu_q       <= 1'b0;
              ir_valid_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ad       = ad_q;
  assign ir       = ir_q;
  assign mem_rq   = mem_rq_q;
  assign ir_valid = ir_valid_q;
  assign cu_      = cu_q;
  assign busy     = (state_q != IDLE);
`ifdef IFETCH_TIMEOUT_EN
  assign alarm    = alarm_q;
`else
  assign alarm    = 1'b0;
`endif

endmodule
